// File: rtl/bank_arb_resp_demux.sv
// -----------------------------------------------------------------------------
// bank_arb_resp_demux
//
// Sits in front of one TCDM bank. Arbitrates among NumIn master requests with a
// round-robin arbiter, forwards the winner's request to the bank, carries the
// winner's index through a RespLat-deep pipeline and raises vld_o only for the
// master whose response is returning. The bank read data is broadcast to all
// masters, and each master qualifies it with its own vld_o bit.
//
// Parameters:
//   NumIn         number of requesting masters (>= 1)
//   ReqDataWidth  request payload width (address/wdata/be packed by caller)
//   RespDataWidth response payload width
//   RespLat       bank response latency in cycles (>= 1)
//   WriteRespOn   when set, writes also produce a vld_o pulse
//
// Ports:
//   clk_i, rst_i    clock; synchronous active-high reset
//   req_i, wen_i    per-master request and write enable
//   data_i          per-master request payload
//   gnt_o           per-master grant, one-hot or zero
//   vld_o           per-master response valid, one-hot or zero
//   rdata_o         bank read data replicated to every master
//   req_o           request to the bank (OR of all requests)
//   wen_o, data_o   winner's write enable and payload (index 0 when idle)
//   gnt_i           bank grant
//   rdata_i         bank read data, valid RespLat cycles after the handshake
//
// Optional feature (macro BANK_ARB_CONFLICT_CNT_EN):
//   conflict_cnt_o  16-bit saturating count of cycles with two or more
//                   simultaneous requests
// -----------------------------------------------------------------------------
module bank_arb_resp_demux #(
  parameter int unsigned NumIn         = 8,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned RespLat       = 1,
  parameter bit          WriteRespOn   = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumIn-1:0]                      req_i,
  input  logic [NumIn-1:0]                      wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]    data_i,
  output logic [NumIn-1:0]                      gnt_o,
  output logic [NumIn-1:0]                      vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]   rdata_o,
  output logic                                  req_o,
  output logic                                  wen_o,
  output logic [ReqDataWidth-1:0]               data_o,
  input  logic                                  gnt_i,
  input  logic [RespDataWidth-1:0]              rdata_i
`ifdef BANK_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]                           conflict_cnt_o
`endif
);

  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

  logic [IdxW-1:0]    winner;
  logic [IdxW-1:0]    last_idx;
  logic               hs;
  logic               stage_vld;
  logic [RespLat-1:0] vld_q;

  assign req_o = |req_i;
  assign hs    = req_o & gnt_i;

  // Winner selection only looks at req_i and the pointer, so gnt_i never
  // feeds back into the choice of master.
  assign wen_o  = wen_i[winner];
  assign data_o = data_i[winner];

  // Writes are filtered out of the response stream unless WriteRespOn is set.
  assign stage_vld = hs & (~wen_o | WriteRespOn);

  generate
    if (NumIn == 1) begin : g_single
      assign winner   = '0;
      assign last_idx = '0;
    end else begin : g_rr
      localparam int unsigned CW = IdxW + 1;

      logic [IdxW-1:0]               rr_q;
      logic [IdxW-1:0]               rr_d;
      logic [CW-1:0]                 cand;
      logic                          found;
      logic [RespLat-1:0][IdxW-1:0]  idx_q;

      // Cyclic scan starting at rr_q; the first requesting index wins.
      // NOTE: every signal driven here gets a default first, otherwise paths
      // that skip an assignment would infer a latch.
      always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
          cand = {1'b0, rr_q} + CW'(k);
          if (cand >= CW'(NumIn)) cand = cand - CW'(NumIn);
          if (!found && req_i[cand[IdxW-1:0]]) begin
            winner = cand[IdxW-1:0];
            found  = 1'b1;
          end
        end
      end

      // The pointer only moves on a handshake, so a stalled master keeps its
      // priority until it is served.
      always_comb begin
        rr_d = rr_q;
        if (hs) rr_d = (winner == IdxW'(NumIn - 1)) ? '0 : winner + IdxW'(1);
      end

      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples pre-edge values regardless of statement order.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rr_q  <= '0;
          idx_q <= '0;
        end else begin
          rr_q     <= rr_d;
          idx_q[0] <= winner;
          for (int unsigned s = 1; s < RespLat; s++) idx_q[s] <= idx_q[s-1];
        end
      end

      assign last_idx = idx_q[RespLat-1];
    end
  endgenerate

  // NOTE: the response pipeline is reset, not just its valid bits' consumer,
  // so that in-flight responses are dropped cleanly on a mid-operation reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= stage_vld;
      for (int unsigned s = 1; s < RespLat; s++) vld_q[s] <= vld_q[s-1];
    end
  end

  always_comb begin
    gnt_o         = '0;
    gnt_o[winner] = hs;
  end

  // Decoded straight from the last pipeline register, so vld_o is glitch-free
  // and lands exactly RespLat cycles after the handshake.
  always_comb begin
    vld_o           = '0;
    vld_o[last_idx] = vld_q[RespLat-1];
  end

  assign rdata_o = {NumIn{rdata_i}};

`ifdef BANK_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_q <= '0;
    end else if (($countones(req_i) >= 2) && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_bank_arb_resp_demux.sv
// -----------------------------------------------------------------------------
// tb_bank_arb_resp_demux
//
// Three instances share one stimulus stream:
//   u_a  NumIn=4, RespLat=1, WriteRespOn=1
//   u_b  NumIn=4, RespLat=3, WriteRespOn=0
//   u_c  NumIn=1, RespLat=2 (fed from master 0 only)
// A round-robin reference model predicts grants and the winner's payload;
// every handshake pushes the expected response onto a per-instance queue that
// is popped when the response is due.
// -----------------------------------------------------------------------------
module tb_bank_arb_resp_demux;

  localparam int N = 4;

  typedef struct {
    int         due;
    logic [3:0] vec;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]       req;
  logic [N-1:0]       wen;
  logic [N-1:0][31:0] data;
  logic               gnt;
  logic [31:0]        rdata;

  logic [N-1:0]       gnt_a, vld_a, gnt_b, vld_b;
  logic [N-1:0][31:0] rdata_a, rdata_b;
  logic               req_oa, wen_oa, req_ob, wen_ob;
  logic [31:0]        data_oa, data_ob;

  logic [0:0]         gnt_c, vld_c;
  logic [0:0][31:0]   rdata_c;
  logic               req_oc, wen_oc;
  logic [31:0]        data_oc;

`ifdef BANK_ARB_CONFLICT_CNT_EN
  logic [15:0] cnt_a, cnt_b, cnt_c;
`endif

  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32),
                        .RespLat(1), .WriteRespOn(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wen_i(wen), .data_i(data),
    .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdata_a), .req_o(req_oa),
    .wen_o(wen_oa), .data_o(data_oa), .gnt_i(gnt), .rdata_i(rdata)
`ifdef BANK_ARB_CONFLICT_CNT_EN
    , .conflict_cnt_o(cnt_a)
`endif
  );

  bank_arb_resp_demux #(.NumIn(4), .ReqDataWidth(32), .RespDataWidth(32),
                        .RespLat(3), .WriteRespOn(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wen_i(wen), .data_i(data),
    .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdata_b), .req_o(req_ob),
    .wen_o(wen_ob), .data_o(data_ob), .gnt_i(gnt), .rdata_i(rdata)
`ifdef BANK_ARB_CONFLICT_CNT_EN
    , .conflict_cnt_o(cnt_b)
`endif
  );

  bank_arb_resp_demux #(.NumIn(1), .ReqDataWidth(32), .RespDataWidth(32),
                        .RespLat(2), .WriteRespOn(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(req[0:0]), .wen_i(wen[0:0]),
    .data_i(data[0:0]), .gnt_o(gnt_c), .vld_o(vld_c), .rdata_o(rdata_c),
    .req_o(req_oc), .wen_o(wen_oc), .data_o(data_oc), .gnt_i(gnt),
    .rdata_i(rdata)
`ifdef BANK_ARB_CONFLICT_CNT_EN
    , .conflict_cnt_o(cnt_c)
`endif
  );

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;
  int    rr    = 0;
  int    cnt_model = 0;
  resp_t q_a[$];
  resp_t q_b[$];
  resp_t q_c[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  // Compare everything visible in the current cycle against the model.
  task automatic check_cycle();
    int         win;
    logic       hs;
    logic [3:0] exp_gnt;
    logic [3:0] exp_v;
    win     = model_winner();
    hs      = (|req) & gnt;
    exp_gnt = hs ? 4'(1 << win) : 4'b0000;

    check("gnt_a",  64'(gnt_a),  64'(exp_gnt));
    check("gnt_b",  64'(gnt_b),  64'(exp_gnt));
    check("req_o",  64'(req_oa), 64'(|req));
    check("wen_o",  64'(wen_oa), 64'(wen[win]));
    check("data_o", 64'(data_oa), 64'(data[win]));
    check("data_ob", 64'(data_ob), 64'(data[win]));
    for (int i = 0; i < N; i++) check("rdata_a", 64'(rdata_a[i]), 64'(rdata));
    check("rdata_c", 64'(rdata_c[0]), 64'(rdata));
    check("gnt_c",  64'(gnt_c),  64'(req[0] & gnt));
    check("data_oc", 64'(data_oc), 64'(data[0]));

    exp_v = 4'b0000;
    if (q_a.size() > 0 && q_a[0].due == cyc) exp_v = q_a.pop_front().vec;
    check("vld_a", 64'(vld_a), 64'(exp_v));
    exp_v = 4'b0000;
    if (q_b.size() > 0 && q_b[0].due == cyc) exp_v = q_b.pop_front().vec;
    check("vld_b", 64'(vld_b), 64'(exp_v));
    exp_v = 4'b0000;
    if (q_c.size() > 0 && q_c[0].due == cyc) exp_v = q_c.pop_front().vec;
    check("vld_c", 64'(vld_c), 64'(exp_v));
`ifdef BANK_ARB_CONFLICT_CNT_EN
    check("conflict_cnt", 64'(cnt_a), 64'(cnt_model));
`endif
  endtask

  // Advance the model across the clock edge that just happened.
  task automatic update_model();
    int   win;
    logic hs;
    win = model_winner();
    hs  = (|req) & gnt;
    if (rst) begin
      rr = 0;
      cnt_model = 0;
      q_a.delete();
      q_b.delete();
      q_c.delete();
    end else begin
      if ($countones(req) >= 2 && cnt_model < 65535) cnt_model++;
      if (hs) begin
        q_a.push_back('{due: cyc + 1, vec: 4'(1 << win)});
        if (!wen[win]) q_b.push_back('{due: cyc + 3, vec: 4'(1 << win)});
        rr = (win + 1) % N;
      end
      if (req[0] & gnt) q_c.push_back('{due: cyc + 2, vec: 4'b0001});
    end
    cyc++;
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] w,
                      input logic g, input logic rs);
    req = r;
    wen = w;
    gnt = g;
    rst = rs;
    for (int i = 0; i < N; i++) data[i] = $urandom;
    rdata = $urandom;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    wen   = '0;
    gnt   = 1'b0;
    data  = '0;
    rdata = '0;
    @(posedge clk);
    #1;

    // Reset state
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    idle(2);

    // Single master 2 handshake; then master 3 must hold priority (rr=3)
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    idle(1);
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    idle(3);

    // Full contention rotation with wrap back to master 0
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    repeat (5) step(4'b1111, 4'b0000, 1'b1, 1'b0);
    idle(3);

    // Stall with two requesters; master 0 keeps priority, then master 1
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    repeat (3) step(4'b0011, 4'b0000, 1'b0, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 1'b0);
    step(4'b0011, 4'b0000, 1'b1, 1'b0);
    idle(3);

    // Back-to-back handshakes from masters 1, 2, 3
    step(4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    step(4'b1000, 4'b0000, 1'b1, 1'b0);
    idle(4);

    // Write then read from master 2 (u_b filters the write)
    step(4'b0100, 4'b0100, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 1'b0);
    idle(4);

    // Reset right after a handshake drops the response and clears rr
    step(4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    idle(4);
    step(4'b1111, 4'b0000, 1'b0, 1'b0);

    // Conflict cycles
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    repeat (5) step(4'b0110, 4'b0000, 1'b0, 1'b0);
    idle(1);

    // Random traffic with occasional resets
    repeat (400) step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 49) == 0));
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
